// File: rtl/key_pkg.sv
// Shared debounce FSM encoding, default debounce count and counter-width helper
// for the key/mode controller.
package key_pkg;

   localparam logic [25:0] DebMaxDefault = 26'd999_999;

   typedef logic [1:0] deb_state_t;

   localparam deb_state_t StIdle        = 2'd0;
   localparam deb_state_t StPressWait   = 2'd1;
   localparam deb_state_t StPressed     = 2'd2;
   localparam deb_state_t StReleaseWait = 2'd3;

   // Smallest counter width that holds deb_max (at least one bit).
   function automatic int unsigned cnt_width(input logic [25:0] deb_max);
      int unsigned w;
      w = $clog2(int'(deb_max) + 1);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int unsigned DebCntW = cnt_width(DebMaxDefault);

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, four-state debounce FSM with saturating
// counter, and a registered single-cycle press pulse.
module key_debounce
   import key_pkg::*;
#(
   parameter logic [25:0] DEB_MAX = DebMaxDefault
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_ni,
   output logic press_o
);

   localparam int unsigned CntW = (DEB_MAX == DebMaxDefault) ? DebCntW : cnt_width(DEB_MAX);
   localparam logic [CntW-1:0] CntMax = CntW'(DEB_MAX);

   logic            sync1_q, sync2_q;
   deb_state_t      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            press_q, press_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= StIdle;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_ni;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (!sync2_q) begin
               state_d = StPressWait;
               cnt_d   = '0;
            end
         end
         StPressWait: begin
            if (sync2_q) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = StPressed;
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StPressed: begin
            if (sync2_q) begin
               state_d = StReleaseWait;
               cnt_d   = '0;
            end
         end
         StReleaseWait: begin
            if (!sync2_q) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign press_o = press_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Run/mode key controller for an LED chaser. Define KEY_AUTORUN_EN to have the
// chaser running straight out of reset.
module key_mode_ctrl
   import key_pkg::*;
#(
   parameter logic [25:0] DEB_MAX = DebMaxDefault
) (
   input  logic CP,
   input  logic Rst,
   input  logic Key_run,
   input  logic Key_mode,
   output logic En,
   output logic Dn,
   output logic Run
);

`ifdef KEY_AUTORUN_EN
   localparam logic RunRst = 1'b1;
`else
   localparam logic RunRst = 1'b0;
`endif

   logic run_pulse, mode_pulse;
   logic run_q, run_d;
   logic dn_q, dn_d;
   logic en_q, en_d;

   key_debounce #(
      .DEB_MAX (DEB_MAX)
   ) u_run_key (
      .clk_i   (CP),
      .rst_i   (Rst),
      .key_ni  (Key_run),
      .press_o (run_pulse)
   );

   key_debounce #(
      .DEB_MAX (DEB_MAX)
   ) u_mode_key (
      .clk_i   (CP),
      .rst_i   (Rst),
      .key_ni  (Key_mode),
      .press_o (mode_pulse)
   );

   assign run_d = run_q ^ run_pulse;
   assign dn_d  = dn_q ^ mode_pulse;
   // A mode press drops En for one cycle so the chaser reloads the new pattern.
   assign en_d  = run_d & ~mode_pulse;

   always_ff @(posedge CP or posedge Rst) begin
      if (Rst) begin
         run_q <= RunRst;
         dn_q  <= 1'b1;
         en_q  <= RunRst;
      end else begin
         run_q <= run_d;
         dn_q  <= dn_d;
         en_q  <= en_d;
      end
   end

   assign Run = run_q;
   assign Dn  = dn_q;
   assign En  = en_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl: directed scenarios plus random key activity, checked
// every cycle against a run-length model of the debounce rules.
module tb_key_mode_ctrl;

   localparam logic [25:0] DebMax = 26'd9;
   localparam int          Di     = 9;

`ifdef KEY_AUTORUN_EN
   localparam logic RunRst = 1'b1;
`else
   localparam logic RunRst = 1'b0;
`endif
   localparam logic RunOn = ~RunRst;

   logic CP       = 1'b0;
   logic Rst      = 1'b1;
   logic Key_run  = 1'b1;
   logic Key_mode = 1'b1;
   logic En, Dn, Run;

   int checks = 0;
   int errors = 0;

   key_mode_ctrl #(
      .DEB_MAX (DebMax)
   ) dut (
      .CP       (CP),
      .Rst      (Rst),
      .Key_run  (Key_run),
      .Key_mode (Key_mode),
      .En       (En),
      .Dn       (Dn),
      .Run      (Run)
   );

   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model: a press fires when an armed key's synchronized level has been low for
   // DebMax+2 consecutive samples; it re-arms after DebMax+2 consecutive high samples.
   bit ms1 [2];
   bit ms2 [2];
   bit armed [2];
   bit pend [2];
   int low_run [2];
   int high_run [2];
   bit m_run, m_dn, m_en;

   always @(posedge CP) begin
      bit raw [2];
      bit s;
      if (Rst) begin
         for (int k = 0; k < 2; k++) begin
            ms1[k] = 1'b1; ms2[k] = 1'b1; armed[k] = 1'b1; pend[k] = 1'b0;
            low_run[k] = 0; high_run[k] = 0;
         end
         m_run = RunRst; m_en = RunRst; m_dn = 1'b1;
      end else begin
         raw[0] = Key_run;
         raw[1] = Key_mode;
         m_run = m_run ^ pend[0];
         m_dn  = m_dn ^ pend[1];
         m_en  = m_run & ~pend[1];
         for (int k = 0; k < 2; k++) begin
            s = ms2[k];
            ms2[k] = ms1[k];
            ms1[k] = raw[k];
            pend[k] = 1'b0;
            if (!s) begin
               high_run[k] = 0;
               low_run[k]++;
               if (armed[k] && low_run[k] == Di + 2) begin
                  pend[k] = 1'b1;
                  armed[k] = 1'b0;
               end
            end else begin
               low_run[k] = 0;
               high_run[k]++;
               if (!armed[k] && high_run[k] == Di + 2) armed[k] = 1'b1;
            end
         end
      end
      #1;
      chk("model_run", Run, m_run);
      chk("model_dn", Dn, m_dn);
      chk("model_en", En, m_en);
   end

   initial begin
      repeat (2) @(posedge CP);
      @(negedge CP) Rst = 1'b0;
      chk("rst_run", Run, RunRst);
      chk("rst_en", En, RunRst);
      chk("rst_dn", Dn, 1'b1);

      // Run press: toggles exactly DebMax+5 edges after the first low sample.
      @(negedge CP) Key_run = 1'b0;
      repeat (Di + 4) @(posedge CP);
      #1 chk("run_early", Run, RunRst);
      @(posedge CP);
      #1 chk("run_latency", Run, RunOn);
      chk("en_latency", En, RunOn);
      repeat (40) @(negedge CP);
      Key_run = 1'b1;
      repeat (2 * Di + 10) @(posedge CP);
      #1 chk("run_hold_release", Run, RunOn);

      // Mode key bounces, then a clean hold.
      @(negedge CP);
      for (int i = 0; i < 3; i++) begin
         Key_mode = 1'b0;
         repeat (5) @(negedge CP);
         Key_mode = 1'b1;
         repeat (2) @(negedge CP);
      end
      chk("dn_bounce", Dn, 1'b1);
      Key_mode = 1'b0;
      repeat (Di + 4) @(posedge CP);
      #1 chk("dn_early", Dn, 1'b1);
      @(posedge CP);
      #1 chk("dn_toggle", Dn, 1'b0);
      chk("en_strobe", En, 1'b0);
      @(posedge CP);
      #1 chk("en_restore", En, RunOn);
      repeat (20) @(negedge CP);
      Key_mode = 1'b1;
      repeat (2 * Di + 10) @(negedge CP);

      // Toggle Run back, then press both keys together.
      Key_run = 1'b0;
      repeat (Di + 8) @(negedge CP);
      Key_run = 1'b1;
      repeat (2 * Di + 8) @(negedge CP);
      chk("run_off", Run, RunRst);
      Key_run = 1'b0;
      Key_mode = 1'b0;
      repeat (Di + 5) @(posedge CP);
      #1 chk("both_run", Run, RunOn);
      chk("both_dn", Dn, 1'b1);
      chk("both_en", En, 1'b0);
      @(posedge CP);
      #1 chk("both_en_after", En, RunOn);
      @(negedge CP);
      Key_run = 1'b1;
      Key_mode = 1'b1;
      repeat (2 * Di + 10) @(negedge CP);

      // Reset mid-debounce with the key still held.
      Key_run = 1'b0;
      repeat (8) @(posedge CP);
      @(negedge CP) Rst = 1'b1;
      #1 chk("midrst_run", Run, RunRst);
      chk("midrst_en", En, RunRst);
      chk("midrst_dn", Dn, 1'b1);
      repeat (2) @(negedge CP);
      Rst = 1'b0;
      repeat (Di + 4) @(posedge CP);
      #1 chk("midrst_early", Run, RunRst);
      @(posedge CP);
      #1 chk("midrst_latency", Run, RunOn);
      @(negedge CP) Key_run = 1'b1;
      repeat (2 * Di + 10) @(negedge CP);

      // Random key activity with occasional resets.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            Rst = 1'b1;
            @(negedge CP);
            Rst = 1'b0;
         end
         Key_run  = 1'($urandom_range(0, 1));
         Key_mode = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 3 * Di)) @(negedge CP);
      end
      Key_run = 1'b1;
      Key_mode = 1'b1;
      repeat (3 * Di) @(negedge CP);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
